data_memory_copier: RTL and testbench
=====================================

# data_memory_copier

Initiator-side master for the DataMemory port of the single-cycle datapath. It drives the `address` / `data_write` / `memo_read` / `memo_write` bus and consumes `data_read`. On a `start` request it copies a block of `length` 16-bit words from `src_addr` to `dst_addr`, one word at a time, then pulses `done`. It sits beside the core's load/store path and takes the memory port only while `busy` is high; the arbitration mux is outside this block.

## Interface
- `DATA_WIDTH`, 16, width of a memory word
- `ADDR_WIDTH`, 16, width of a word address
- `clk`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  copy request; sampled only in IDLE
- `src_addr`  in  ADDR_WIDTH  first source word address, latched on an accepted start
- `dst_addr`  in  ADDR_WIDTH  first destination word address, latched on an accepted start
- `length`  in  16  word count, latched on an accepted start; 0 means no-op
- `busy`  out  1  high whenever the state is not IDLE
- `done`  out  1  one-cycle pulse at completion
- `address`  out  ADDR_WIDTH  memory address
- `data_write`  out  DATA_WIDTH  memory write data
- `memo_read`  out  1  memory read enable
- `memo_write`  out  1  memory write enable; memory commits on the rising edge
- `data_read`  in  DATA_WIDTH  memory read data; combinational from `address` while `memo_read` is high
- `checksum`  out  DATA_WIDTH  only with `MEMCOPY_CHECKSUM_EN`

## Operation
- States: IDLE, READ, WRITE, DONE.
- **IDLE:**
  - All bus outputs are 0.
  - `start`=1 latches `src_ptr`, `dst_ptr` and `remaining`.
  - Next state is DONE if `length`==0, otherwise READ.
- **READ:**
  - `address`=`src_ptr`, `memo_read`=1.
  - At the edge, `hold` <= `data_read` and `src_ptr` <= `src_ptr`+1.
  - Next state is WRITE.
- **WRITE:**
  - `address`=`dst_ptr`, `data_write`=`hold`, `memo_write`=1.
  - At the edge, `dst_ptr` <= `dst_ptr`+1 and `remaining` <= `remaining`-1.
  - Next state is DONE if `remaining`==1, otherwise READ.
- **DONE:**
  - `done`=1 and all bus enables are 0.
  - Next state is IDLE.
- `start` in any state other than IDLE is ignored and is not queued.
- Pointer arithmetic is modulo 2^ADDR_WIDTH: 0xFFFF+1 wraps to 0x0000 with no error.
- The copy always runs in ascending address order. Overlapping regions with dst > src replicate source words forward; this is defined behaviour, not an error.
- `memo_read` and `memo_write` are never high in the same cycle.
- `address` and `data_write` are 0 whenever their respective enable is low.

## Timing
- Bus outputs and `done` decode directly from the state register and pointers; there is no output register stage.
- Per word: 2 cycles (READ then WRITE).
- Start accepted at edge k: READ occupies cycle k+1, and `done` is high in cycle k+2N+1. For N=0, `done` is high in cycle k+1.
- `busy` rises in the cycle after the accepted start and falls in the cycle after `done`.
- The earliest next start is sampled in the first IDLE cycle after DONE.
- Reset values: state IDLE, all outputs 0, `hold`/pointers/`remaining` 0, `checksum` 0.
- Reset in mid-operation:
  - State is IDLE from the next cycle.
  - If reset is sampled during a WRITE cycle, that write still commits at the same edge, because the enables were already driven that cycle.
  - No `done` pulse is produced.

## Configuration
- `MEMCOPY_CHECKSUM_EN` defined:
  - Adds the `checksum` port and register.
  - Cleared to 0 on an accepted start.
  - At each READ edge, `checksum` <= `checksum` + `data_read`, modulo 2^16.
  - Valid when `done` pulses; holds until the next accepted start.
- Not defined: no `checksum` port and no adder. All other behaviour is identical.

## Structure
- Shared package `memcopy_pkg`:
  - 2-bit state encoding constants: IDLE=0, READ=1, WRITE=2, DONE=3.
  - Default `DATA_WIDTH` and `ADDR_WIDTH` constants.
- One natural sub-module, `memcopy_ptr_unit`:
  - Holds `src_ptr`, `dst_ptr` and `remaining`.
  - Inputs: load, src_inc, dst_inc strobes.
  - Outputs: `remaining`==1 flag.
- The top level holds the FSM, `hold` and the optional checksum.

## Test plan
- Preload mem[0..3] = 0x1111, 0x2222, 0x3333, 0x4444; start with src=0, dst=8, len=4 -> mem[8..11] match the source; `done` high exactly 9 cycles after the start edge; `checksum`=0xAAAA.
- Start with len=0 -> `done` in the next cycle; `memo_read` and `memo_write` never assert; memory unchanged.
- Preload mem[0xFFFF]=0xBEEF and mem[0x0000]=0xCAFE; src=0xFFFF, dst=0x0010, len=2 -> mem[0x10]=0xBEEF, mem[0x11]=0xCAFE; read addresses are 0xFFFF then 0x0000.
- Pulse `start` with new operands while busy (len=3 copy in flight) -> ignored; only the original 3 words are written; a single `done`.
- Preload mem[0..1] = 0xFFFF, 0x0002; len=2 -> `checksum`=0x0001 (wrap).
- Copy with len=4; assert reset during the second READ -> IDLE next cycle; all outputs 0; only dst[0] written; no `done` pulse.

Source files
------------

// File: rtl/memcopy_pkg.sv
// Shared types and defaults for the DataMemory block copier.
package memcopy_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 16;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 16;
  localparam int unsigned LENGTH_WIDTH       = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/memcopy_ptr_unit.sv
// Source/destination pointers and remaining-word counter for the block copier.
module memcopy_ptr_unit
  import memcopy_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned LEN_WIDTH  = LENGTH_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  src_inc,
  input  logic                  dst_inc,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic [ADDR_WIDTH-1:0] src_ptr,
  output logic [ADDR_WIDTH-1:0] dst_ptr,
  output logic                  last
);

  logic [LEN_WIDTH-1:0] remaining;

  // Pointers wrap naturally at 2^ADDR_WIDTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
    end else if (load) begin
      src_ptr   <= src_addr;
      dst_ptr   <= dst_addr;
      remaining <= length;
    end else begin
      if (src_inc)
        src_ptr <= src_ptr + ADDR_WIDTH'(1);
      if (dst_inc) begin
        dst_ptr   <= dst_ptr + ADDR_WIDTH'(1);
        remaining <= remaining - LEN_WIDTH'(1);
      end
    end
  end

  assign last = (remaining == LEN_WIDTH'(1));

endmodule

// File: rtl/data_memory_copier.sv
// DataMemory-port master copying a block of words from src_addr to dst_addr.
// Optional running sum of read words when MEMCOPY_CHECKSUM_EN is defined.
module data_memory_copier
  import memcopy_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   src_addr,
  input  logic [ADDR_WIDTH-1:0]   dst_addr,
  input  logic [LENGTH_WIDTH-1:0] length,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_WIDTH-1:0]   address,
  output logic [DATA_WIDTH-1:0]   data_write,
  output logic                    memo_read,
  output logic                    memo_write,
  input  logic [DATA_WIDTH-1:0]   data_read
`ifdef MEMCOPY_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0]   checksum
`endif
);

  state_t                state;
  logic [DATA_WIDTH-1:0] hold;
  logic [ADDR_WIDTH-1:0] src_ptr;
  logic [ADDR_WIDTH-1:0] dst_ptr;
  logic                  last;
  logic                  load;

  assign load = (state == IDLE) && start;

  memcopy_ptr_unit #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LEN_WIDTH  (LENGTH_WIDTH)
  ) u_ptr (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .src_inc  (state == READ),
    .dst_inc  (state == WRITE),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .length   (length),
    .src_ptr  (src_ptr),
    .dst_ptr  (dst_ptr),
    .last     (last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      hold  <= '0;
`ifdef MEMCOPY_CHECKSUM_EN
      checksum <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= (length == '0) ? DONE : READ;
`ifdef MEMCOPY_CHECKSUM_EN
            checksum <= '0;
`endif
          end
        end
        READ: begin
          hold  <= data_read;
          state <= WRITE;
`ifdef MEMCOPY_CHECKSUM_EN
          checksum <= checksum + data_read;
`endif
        end
        WRITE:   state <= last ? DONE : READ;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Bus decodes straight from state; a WRITE in flight when reset is sampled still commits.
  always_comb begin
    busy       = (state != IDLE);
    done       = (state == DONE);
    memo_read  = (state == READ);
    memo_write = (state == WRITE);
    address    = '0;
    data_write = '0;
    if (state == READ)
      address = src_ptr;
    if (state == WRITE) begin
      address    = dst_ptr;
      data_write = hold;
    end
  end

endmodule

// File: tb/tb_data_memory_copier.sv
// Bench for data_memory_copier: directed cases plus random copies against an array model.
module tb_data_memory_copier;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] src_addr;
  logic [15:0] dst_addr;
  logic [15:0] length;
  logic        busy;
  logic        done;
  logic [15:0] address;
  logic [15:0] data_write;
  logic        memo_read;
  logic        memo_write;
  logic [15:0] data_read;
`ifdef MEMCOPY_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  data_memory_copier #(
    .DATA_WIDTH (16),
    .ADDR_WIDTH (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .address    (address),
    .data_write (data_write),
    .memo_read  (memo_read),
    .memo_write (memo_write),
    .data_read  (data_read)
`ifdef MEMCOPY_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  always #5 clk = ~clk;

  logic [15:0] mem     [0:65535] = '{default: '0};
  logic [15:0] exp_mem [0:65535] = '{default: '0};
  logic        pl_en = 1'b0;
  logic [15:0] pl_addr = '0;
  logic [15:0] pl_data = '0;

  assign data_read = memo_read ? mem[address] : '0;

  always @(posedge clk) begin
    if (memo_write)
      mem[address] <= data_write;
    else if (pl_en)
      mem[pl_addr] <= pl_data;
  end

  int          vectors     = 0;
  int          miscompares = 0;
  bit          mon_on      = 0;
  int          done_cnt    = 0;
  int          rd_cnt      = 0;
  int          wr_cnt      = 0;
  logic [15:0] rd_log[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      check("rd_wr_exclusive", 32'(memo_read & memo_write), 32'd0);
      if (!memo_read && !memo_write)
        check("address_idle_zero", 32'(address), 32'd0);
      if (!memo_write)
        check("wdata_idle_zero", 32'(data_write), 32'd0);
      if (done) begin
        check("done_implies_busy", 32'(busy), 32'd1);
        done_cnt++;
      end
      if (memo_read) begin
        rd_cnt++;
        rd_log.push_back(address);
      end
      if (memo_write)
        wr_cnt++;
    end
  end

  task automatic preload(input logic [15:0] a, input logic [15:0] v);
    @(negedge clk);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = v;
    @(posedge clk);
    #1 pl_en = 1'b0;
    exp_mem[a] = v;
  endtask

  task automatic run_copy(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n,
                          input bit interfere);
    int          edges;
    bit          found;
    int          d0;
    logic [15:0] sum;
    logic [15:0] w;
    d0  = done_cnt;
    sum = '0;
    // Reference: ascending word copy over the model memory, overlap included.
    for (int i = 0; i < int'(n); i++) begin
      w = exp_mem[16'(s + i)];
      sum = sum + w;
      exp_mem[16'(d + i)] = w;
    end
    rd_log.delete();
    @(negedge clk);
    src_addr = s;
    dst_addr = d;
    length   = n;
    start    = 1'b1;
    @(posedge clk);
    edges = 0;
    found = 0;
    while (!found && edges < 2 * int'(n) + 8) begin
      @(negedge clk);
      start = interfere && (edges == 2);
      if (start) begin
        src_addr = 16'h0060;
        dst_addr = 16'h0070;
        length   = 16'd5;
      end
      if (edges == 0)
        check("busy_rise", 32'(busy), 32'd1);
      if (done)
        found = 1;
      else begin
        @(posedge clk);
        edges++;
      end
    end
    start = 1'b0;
    check("done_seen", 32'(found), 32'd1);
    check("done_latency", 32'(edges), 32'(2 * int'(n)));
    @(negedge clk);
    check("busy_fall", 32'(busy), 32'd0);
    check("done_one_cycle", 32'(done), 32'd0);
    check("done_count", 32'(done_cnt - d0), 32'd1);
    for (int i = 0; i < int'(n); i++) begin
      check("dst_word", 32'(mem[16'(d + i)]), 32'(exp_mem[16'(d + i)]));
      if (i < rd_log.size())
        check("read_addr", 32'(rd_log[i]), 32'(16'(s + i)));
    end
    check("read_count", 32'(rd_log.size()), 32'(n));
    check("guard_below", 32'(mem[16'(d - 1)]), 32'(exp_mem[16'(d - 1)]));
    check("guard_above", 32'(mem[16'(d + n)]), 32'(exp_mem[16'(d + n)]));
`ifdef MEMCOPY_CHECKSUM_EN
    check("checksum", 32'(checksum), 32'(sum));
`endif
  endtask

  initial begin
    int          rd0;
    int          wr0;
    int          d0;
    logic [15:0] s;
    logic [15:0] d;
    logic [15:0] n;

    reset    = 1'b1;
    start    = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    length   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd", 32'(memo_read), 32'd0);
    check("rst_wr", 32'(memo_write), 32'd0);
    check("rst_addr", 32'(address), 32'd0);
    check("rst_wdata", 32'(data_write), 32'd0);
`ifdef MEMCOPY_CHECKSUM_EN
    check("rst_checksum", 32'(checksum), 32'd0);
`endif
    mon_on = 1;

    // Basic 4-word copy; sum 0xAAAA.
    preload(16'h0000, 16'h1111);
    preload(16'h0001, 16'h2222);
    preload(16'h0002, 16'h3333);
    preload(16'h0003, 16'h4444);
    run_copy(16'h0000, 16'h0008, 16'd4, 0);
    check("basic_w3", 32'(mem[16'h000B]), 32'h4444);

    // Zero length: no bus activity.
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    run_copy(16'h0000, 16'h0020, 16'd0, 0);
    check("len0_no_reads", 32'(rd_cnt - rd0), 32'd0);
    check("len0_no_writes", 32'(wr_cnt - wr0), 32'd0);

    // Source pointer wraps past 0xFFFF.
    preload(16'hFFFF, 16'hBEEF);
    preload(16'h0000, 16'hCAFE);
    run_copy(16'hFFFF, 16'h0010, 16'd2, 0);
    check("wrap_w0", 32'(mem[16'h0010]), 32'hBEEF);
    check("wrap_w1", 32'(mem[16'h0011]), 32'hCAFE);

    // Start pulse mid-copy must be ignored.
    preload(16'h0040, 16'h0A0A);
    preload(16'h0041, 16'h0B0B);
    preload(16'h0042, 16'h0C0C);
    wr0 = wr_cnt;
    run_copy(16'h0040, 16'h0050, 16'd3, 1);
    check("busy_start_writes", 32'(wr_cnt - wr0), 32'd3);
    check("busy_start_no_dst2", 32'(mem[16'h0070]), 32'(exp_mem[16'h0070]));
    repeat (4) @(negedge clk);
    check("busy_start_single_done", 32'(busy), 32'd0);

    // Checksum wraps modulo 2^16.
    preload(16'h0000, 16'hFFFF);
    preload(16'h0001, 16'h0002);
    run_copy(16'h0000, 16'h0030, 16'd2, 0);
    check("cs_copy_w1", 32'(mem[16'h0031]), 32'h0002);

    // Reset during the second READ: only the first word lands, no done.
    preload(16'h0080, 16'h5A5A);
    preload(16'h0081, 16'h6B6B);
    preload(16'h0082, 16'h7C7C);
    preload(16'h0083, 16'h8D8D);
    d0 = done_cnt;
    @(negedge clk);
    src_addr = 16'h0080;
    dst_addr = 16'h0090;
    length   = 16'd4;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("mid_second_read", 32'(memo_read), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_rd", 32'(memo_read), 32'd0);
    check("mid_rst_wr", 32'(memo_write), 32'd0);
    check("mid_rst_addr", 32'(address), 32'd0);
`ifdef MEMCOPY_CHECKSUM_EN
    check("mid_rst_checksum", 32'(checksum), 32'd0);
`endif
    repeat (6) @(negedge clk);
    check("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
    exp_mem[16'h0090] = exp_mem[16'h0080];
    for (int i = 0; i < 4; i++)
      check("mid_rst_dst", 32'(mem[16'(16'h0090 + i)]), 32'(exp_mem[16'(16'h0090 + i)]));

    // Random copies, overlapping forward about half the time.
    for (int t = 0; t < 8; t++) begin
      s = 16'($urandom);
      n = 16'($urandom_range(0, 8));
      if ($urandom_range(0, 1) == 1)
        d = 16'(s + $urandom_range(1, 6));
      else
        d = 16'($urandom);
      for (int i = 0; i < int'(n); i++)
        preload(16'(s + i), 16'($urandom));
      run_copy(s, d, n, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
